apb_bus_master: RTL and testbench
=================================

// Module: apb_bus_master
// PURPOSE
// - APB requester that sits directly upstream of the GPIO and UART peripherals.
// - Accepts single read/write requests on a valid/ready port.
// - Decodes the target from the address and drives APB SETUP/ACCESS phases.
// - Returns read data and an error flag on a one-cycle response strobe.
// PARAMETERS
// - GPIO_BASE       default 32'h4000_0000  region base selecting GPIO (psel=2'b01)
// - UART_BASE       default 32'h4000_1000  region base selecting UART (psel=2'b10)
// - REGION_MASK     default 32'hFFFF_F000  address bits compared against each base
// - TIMEOUT_CYCLES  default 16             max ACCESS cycles; used only with APB_TIMEOUT_EN
// PORTS
// - clk          in   1   single clock for all logic
// - rst_n        in   1   asynchronous reset, active-low
// - req_valid    in   1   request present
// - req_ready    out  1   request accepted when req_valid && req_ready
// - req_wr       in   1   1 = write, 0 = read
// - req_addr     in   32  byte address
// - req_wdata    in   32  write data
// - rsp_valid    out  1   one-cycle response strobe
// - rsp_rdata    out  32  read data; 0 for writes and on errors
// - rsp_err      out  1   decode miss or timeout; qualified by rsp_valid
// - pAdd         out  32  APB address
// - pwData       out  32  APB write data
// - pwr          out  1   APB write
// - psel         out  2   01 = GPIO, 10 = UART, 00 = idle; never 11
// - pen          out  1   APB enable
// - prdata_gpio  in   32  GPIO read data
// - pready_gpio  in   1   GPIO ready
// - prdata_uart  in   32  UART read data
// - pready_uart  in   1   UART ready
// BEHAVIOUR
// - Reset: every output is 0 (req_ready=0 while rst_n=0); state = IDLE.
//   - Asserting rst_n mid-transfer aborts immediately: psel/pen drop, no rsp_valid.
// - FSM states: IDLE, SETUP, ACCESS, RESP.
//   - IDLE: req_ready=1, psel=00, pen=0.
//     - On accept, latch wr/addr/wdata into pAdd/pwData/pwr.
//     - Decode hit: go to SETUP.
//     - Decode miss: go to RESP with err=1; no bus cycle.
//     - Decode uses (addr & REGION_MASK) == base; GPIO wins if both match.
//   - SETUP: psel = decoded code, pen=0, for exactly one cycle; go to ACCESS.
//   - ACCESS: psel held, pen=1.
//     - Addr/data/pwr stay stable for the whole transfer.
//     - Only the selected slave's pready is sampled.
//     - On pready: capture the selected prdata if read (0 if write), err=0, go to RESP.
//   - RESP: rsp_valid=1 for one cycle; psel=00, pen=0, req_ready=0; go to IDLE.
// - Latency:
//   - Accept to rsp_valid is 3 cycles with zero wait states (SETUP, ACCESS, RESP).
//   - Each pready-low cycle in ACCESS adds one cycle.
//   - Decode miss: rsp_valid 1 cycle after accept.
// - Back-to-back:
//   - req_ready is low in SETUP/ACCESS/RESP.
//   - Next accept is earliest the cycle after RESP.
//   - psel returns to 00 for at least one cycle between transfers.
// - pready arriving in SETUP is ignored; pready from the non-selected slave is ignored.
// - rsp_rdata/rsp_err hold their last values between strobes.
// CONFIGURATION
// - Macro APB_TIMEOUT_EN defined:
//   - 5-bit ACCESS-cycle counter, cleared on entering ACCESS.
//   - If pready is still low when the count reaches TIMEOUT_CYCLES, go to RESP with err=1, rdata=0.
//   - psel/pen drop in RESP as normal.
// - Macro APB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits for pready indefinitely.
//   - rsp_err is set only by decode miss.
// STRUCTURE
// - Package apb_pkg:
//   - state enum/localparams (IDLE, SETUP, ACCESS, RESP).
//   - PSEL_NONE=2'b00, PSEL_GPIO=2'b01, PSEL_UART=2'b10.
//   - Default base and mask constants.
// - Single module; the address decoder is a combinational function.
// - No sub-module needed; shared with the GPIO/UART side via apb_pkg only.
// TESTING
// - Write 32'hA5 to 32'h4000_1004, pready_uart=1:
//   - SETUP psel=10 pen=0, then ACCESS pen=1 pwr=1.
//   - rsp_valid at +3 with err=0, rdata=0.
// - Read 32'h4000_0008, pready_gpio low 2 cycles, prdata_gpio=32'h1234:
//   - psel=01 held 4 cycles.
//   - rsp_valid at +5, rdata=32'h1234, err=0.
// - Read 32'h5000_0000 (no match):
//   - psel stays 00.
//   - rsp_valid at +1 with err=1, rdata=0.
// - UART read with pready_gpio=1 and pready_uart=0 for 3 cycles:
//   - Transfer completes only on pready_uart.
//   - GPIO ready is ignored.
// - rst_n low during ACCESS:
//   - psel/pen/req_ready drop asynchronously; no rsp_valid.
//   - After release, IDLE with req_ready=1.
// - APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready_uart never asserts:
//   - rsp_valid with err=1 after 16 ACCESS cycles.
//   - psel=00 in RESP.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions for the bus master and the GPIO/UART peripherals.
// Holds the state encoding, the psel codes, the default address map and the address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_GPIO = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  localparam logic [31:0] DEF_GPIO_BASE   = 32'h4000_0000;
  localparam logic [31:0] DEF_UART_BASE   = 32'h4000_1000;
  localparam logic [31:0] DEF_REGION_MASK = 32'hFFFF_F000;

  // GPIO is tested first so it wins when both regions match.
  function automatic logic [1:0] apb_decode(input logic [31:0] addr,
                                            input logic [31:0] gpio_base,
                                            input logic [31:0] uart_base,
                                            input logic [31:0] mask);
    if ((addr & mask) == gpio_base)      return PSEL_GPIO;
    else if ((addr & mask) == uart_base) return PSEL_UART;
    else                                 return PSEL_NONE;
  endfunction

endpackage

// File: rtl/apb_bus_master.sv
// Single-request APB requester for the GPIO and UART peripherals.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_bus_master
  import apb_pkg::*;
#(
  parameter logic [31:0] GPIO_BASE      = DEF_GPIO_BASE,
  parameter logic [31:0] UART_BASE      = DEF_UART_BASE,
  parameter logic [31:0] REGION_MASK    = DEF_REGION_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] pAdd,
  output logic [31:0] pwData,
  output logic        pwr,
  output logic [1:0]  psel,
  output logic        pen,
  input  logic [31:0] prdata_gpio,
  input  logic        pready_gpio,
  input  logic [31:0] prdata_uart,
  input  logic        pready_uart
);

  apb_state_t  state;
  logic [1:0]  sel;
  logic [1:0]  dec_sel;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..32");
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] to_cnt;
`endif

  assign dec_sel = apb_decode(req_addr, GPIO_BASE, UART_BASE, REGION_MASK);

  // Only the slave latched at accept time may complete the transfer.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    case (sel)
      PSEL_GPIO: begin
        sel_ready = pready_gpio;
        sel_rdata = prdata_gpio;
      end
      PSEL_UART: begin
        sel_ready = pready_uart;
        sel_rdata = prdata_uart;
      end
      default: ;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them immediately.
  assign req_ready = rst_n && (state == IDLE);
  assign psel      = (state == SETUP || state == ACCESS) ? sel : PSEL_NONE;
  assign pen       = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= PSEL_NONE;
      pAdd      <= '0;
      pwData    <= '0;
      pwr       <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            pAdd   <= req_addr;
            pwData <= req_wdata;
            pwr    <= req_wr;
            sel    <= dec_sel;
            if (dec_sel != PSEL_NONE) begin
              state <= SETUP;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          state <= ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_rdata <= pwr ? '0 : sel_rdata;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 5'd1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_master.sv
// Self-checking bench for apb_bus_master: table vectors, random transfers against a
// transaction-level model, plus reset-abort and (with APB_TIMEOUT_EN) timeout sequences.
module tb_apb_bus_master;

  localparam logic [31:0] G_BASE = 32'h4000_0000;
  localparam logic [31:0] U_BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] pAdd;
  logic [31:0] pwData;
  logic        pwr;
  logic [1:0]  psel;
  logic        pen;
  logic [31:0] prdata_gpio;
  logic        pready_gpio;
  logic [31:0] prdata_uart;
  logic        pready_uart;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  logic        prev_err   = 1'b0;
  logic [31:0] prev_rdata = '0;

  apb_bus_master #(
    .GPIO_BASE     (G_BASE),
    .UART_BASE     (U_BASE),
    .REGION_MASK   (32'hFFFF_F000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .pAdd       (pAdd),
    .pwData     (pwData),
    .pwr        (pwr),
    .psel       (psel),
    .pen        (pen),
    .prdata_gpio(prdata_gpio),
    .pready_gpio(pready_gpio),
    .prdata_uart(prdata_uart),
    .pready_uart(pready_uart)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int unsigned waits;
    logic [1:0]  exp_psel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: address region -> target, then response and latency.
  function automatic vec_t model(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] prdata,
                                 input int unsigned waits);
    vec_t v;
    int unsigned region;
    region      = addr / 4096;
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.prdata    = prdata;
    v.waits     = waits;
    if (region == G_BASE / 4096)      v.exp_psel = 2'b01;
    else if (region == U_BASE / 4096) v.exp_psel = 2'b10;
    else                              v.exp_psel = 2'b00;
    v.exp_err   = (v.exp_psel == 2'b00);
    v.exp_rdata = (v.exp_err || wr) ? 32'h0 : prdata;
    v.exp_lat   = v.exp_err ? 1 : 3 + waits;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int unsigned n;
    logic sel_rdy;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".ready_idle"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wr    = 1'($urandom);
    for (int unsigned c = 1; c <= v.exp_lat; c++) begin
      // Selected slave shows ready during SETUP (must be ignored); the other slave is always ready.
      sel_rdy = (c == 1) ? 1'b1 : (c - 2 >= v.waits);
      pready_gpio = (v.exp_psel == 2'b01) ? sel_rdy : 1'b1;
      pready_uart = (v.exp_psel == 2'b10) ? sel_rdy : 1'b1;
      prdata_gpio = (v.exp_psel == 2'b01) ? v.prdata : $urandom;
      prdata_uart = (v.exp_psel == 2'b10) ? v.prdata : $urandom;
      if (c == v.exp_lat) begin
        chk({tag, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, ".rsp_err"},   {31'h0, rsp_err}, {31'h0, v.exp_err});
        chk({tag, ".resp_psel"}, {30'h0, psel}, 32'h0);
        chk({tag, ".resp_pen"},  {31'h0, pen}, 32'h0);
        chk({tag, ".resp_ready"}, {31'h0, req_ready}, 32'h0);
      end else begin
        chk({tag, ".busy_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, ".busy_ready"}, {31'h0, req_ready}, 32'h0);
        chk({tag, ".psel"}, {30'h0, psel}, {30'h0, v.exp_psel});
        chk({tag, ".pen"},  {31'h0, pen}, (c >= 2) ? 32'h1 : 32'h0);
        chk({tag, ".pAdd"}, pAdd, v.addr);
        chk({tag, ".pwData"}, pwData, v.wdata);
        chk({tag, ".pwr"}, {31'h0, pwr}, {31'h0, v.wr});
        chk({tag, ".hold_rdata"}, rsp_rdata, prev_rdata);
        chk({tag, ".hold_err"}, {31'h0, rsp_err}, {31'h0, prev_err});
      end
      @(posedge clk); #1;
    end
    pready_gpio = 1'b0;
    pready_uart = 1'b0;
    prev_rdata  = v.exp_rdata;
    prev_err    = v.exp_err;
    chk({tag, ".after_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, ".after_psel"}, {30'h0, psel}, 32'h0);
    chk({tag, ".after_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, ".after_rdata"}, rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t table_v[7];
    vec_t v;
    logic [31:0] a;
    int unsigned kind;

    table_v[0] = '{1'b1, 32'h4000_1004, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 2'b10, 1'b0, 32'h0, 3};
    table_v[1] = '{1'b0, 32'h4000_0008, 32'h0,        32'h0000_1234, 2, 2'b01, 1'b0, 32'h0000_1234, 5};
    table_v[2] = '{1'b0, 32'h5000_0000, 32'h0,        32'h1111_1111, 0, 2'b00, 1'b1, 32'h0, 1};
    table_v[3] = '{1'b0, 32'h4000_1010, 32'h0,        32'hDEAD_BEEF, 3, 2'b10, 1'b0, 32'hDEAD_BEEF, 6};
    table_v[4] = '{1'b1, 32'h4000_0FFC, 32'h1357_9BDF, 32'h2222_2222, 1, 2'b01, 1'b0, 32'h0, 4};
    table_v[5] = '{1'b0, 32'h4000_2000, 32'h0,        32'h3333_3333, 0, 2'b00, 1'b1, 32'h0, 1};
    table_v[6] = '{1'b1, 32'h3FFF_FFFC, 32'h4444_4444, 32'h5555_5555, 0, 2'b00, 1'b1, 32'h0, 1};

    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    prdata_gpio = '0; pready_gpio = 1'b0; prdata_uart = '0; pready_uart = 1'b0;
    #1;
    chk("reset.req_ready", {31'h0, req_ready}, 32'h0);
    chk("reset.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset.pAdd", pAdd, 32'h0);
    chk("reset.pwData", pwData, 32'h0);
    chk("reset.pwr", {31'h0, pwr}, 32'h0);
    chk("reset.psel", {30'h0, psel}, 32'h0);
    chk("reset.pen", {31'h0, pen}, 32'h0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_txn(table_v[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: a = G_BASE | ($urandom & 32'hFFC);
        1: a = U_BASE | ($urandom & 32'hFFC);
        2: a = 32'h4000_2000 + ($urandom & 32'hFFFC);
        default: a = $urandom;
      endcase
      v = model(1'($urandom), a, $urandom, $urandom, $urandom_range(0, 4));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted mid-ACCESS aborts the transfer asynchronously.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h4000_0010; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort.in_access_pen", {31'h0, pen}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.psel", {30'h0, psel}, 32'h0);
    chk("abort.pen", {31'h0, pen}, 32'h0);
    chk("abort.req_ready", {31'h0, req_ready}, 32'h0);
    chk("abort.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    prev_rdata = '0;
    prev_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort.after_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("abort.after_ready", {31'h0, req_ready}, 32'h1);
      chk("abort.after_psel", {30'h0, psel}, 32'h0);
    end
    chk("abort.after_err", {31'h0, rsp_err}, 32'h0);

    v = model(1'b0, 32'h4000_0020, 32'h0, 32'hCAFE_F00D, 1);
    run_txn(v, "post_reset");

`ifdef APB_TIMEOUT_EN
    v = '{1'b0, 32'h4000_1008, 32'h0, 32'h7777_7777, 1000, 2'b10, 1'b1, 32'h0, 18};
    run_txn(v, "timeout");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
